// File: rtl/mem_store_serializer.sv
// Serialises one store request (address, 32-bit data, width) onto a byte-wide
// memory write port, least significant byte first, one byte per dclk cycle.
module mem_store_serializer #(
  parameter int ADDR_W      = 32,
  parameter bit CHECK_ALIGN = 1'b1
) (
  input  logic              dclk,
  input  logic              rst,
  input  logic              rdy,
  input  logic              req_i,
  input  logic [ADDR_W-1:0] addr_i,
  input  logic [31:0]       data_i,
  input  logic [1:0]        width_i,
  output logic              busy_o,
  output logic              done_o,
  output logic              err_o,
  output logic [ADDR_W-1:0] addr_mem_o,
  output logic [7:0]        d_mem_o,
  output logic              we_mem_o
);

  // state | meaning
  // IDLE  | waiting for a store request
  // WRITE | driving latched bytes onto the memory port
  typedef enum logic {IDLE, WRITE} state_t;

  state_t            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic [2:0]        nbytes_q, nbytes_d;
  logic [31:0]       data_q, data_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              err_q, err_d;
  logic              we_q, we_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [7:0]        dmem_q, dmem_d;

  logic [2:0]        req_nbytes;
  logic              req_illegal;
  logic [7:0]        next_byte;

  always_comb begin
    case (width_i)
      2'b00:   req_nbytes = 3'd1;
      2'b01:   req_nbytes = 3'd2;
      default: req_nbytes = 3'd4;
    endcase
    req_illegal = (width_i == 2'b11) ||
                  (CHECK_ALIGN && (width_i == 2'b01) && addr_i[0]) ||
                  (CHECK_ALIGN && (width_i == 2'b10) && (addr_i[1:0] != 2'b00));
  end

  // cnt_q indexes the byte to present next; it tops out at 4, never used as an index there
  always_comb begin
    case (cnt_q[1:0])
      2'd1:    next_byte = data_q[15:8];
      2'd2:    next_byte = data_q[23:16];
      2'd3:    next_byte = data_q[31:24];
      default: next_byte = data_q[7:0];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    nbytes_d = nbytes_q;
    data_d   = data_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    err_d    = 1'b0;
    we_d     = we_q;
    addr_d   = addr_q;
    dmem_d   = dmem_q;
    case (state_q)
      IDLE: begin
        we_d = 1'b0;
        if (req_i) begin
          if (req_illegal) begin
            err_d = 1'b1;
          end else begin
            state_d  = WRITE;
            cnt_d    = 3'd1;
            nbytes_d = req_nbytes;
            data_d   = data_i;
            busy_d   = 1'b1;
            we_d     = 1'b1;
            addr_d   = addr_i;
            dmem_d   = data_i[7:0];
          end
        end
      end
      WRITE: begin
        if (cnt_q == nbytes_q) begin
          state_d = IDLE;
          we_d    = 1'b0;
          busy_d  = 1'b0;
          done_d  = 1'b1;
        end else begin
          addr_d = addr_q + ADDR_W'(1);
          dmem_d = next_byte;
          cnt_d  = cnt_q + 3'd1;
        end
      end
    endcase
  end

  always_ff @(posedge dclk) begin
    if (rst) begin
      state_q  <= IDLE;
      cnt_q    <= 3'd0;
      nbytes_q <= 3'd0;
      data_q   <= 32'd0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      err_q    <= 1'b0;
      we_q     <= 1'b0;
      addr_q   <= '0;
      dmem_q   <= 8'd0;
    end else if (rdy) begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      nbytes_q <= nbytes_d;
      data_q   <= data_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      err_q    <= err_d;
      we_q     <= we_d;
      addr_q   <= addr_d;
      dmem_q   <= dmem_d;
    end
  end

  assign busy_o     = busy_q;
  assign done_o     = done_q;
  assign err_o      = err_q;
  assign we_mem_o   = we_q;
  assign addr_mem_o = addr_q;
  assign d_mem_o    = dmem_q;

endmodule

// File: tb/tb_mem_store_serializer.sv
// Bench for mem_store_serializer: one instance with alignment checking, one without,
// both compared every cycle against a transaction-level reference model.
module tb_mem_store_serializer;

  logic dclk = 1'b0;
  always #5 dclk = ~dclk;

  logic        rst, rdy, req_i;
  logic [31:0] addr_i, data_i;
  logic [1:0]  width_i;
  logic [1:0]  busy, done, err, we;
  logic [31:0] amem [2];
  logic [7:0]  dmem [2];

  mem_store_serializer #(.ADDR_W(32), .CHECK_ALIGN(1'b1)) dut (
    .dclk(dclk), .rst(rst), .rdy(rdy), .req_i(req_i), .addr_i(addr_i),
    .data_i(data_i), .width_i(width_i), .busy_o(busy[0]), .done_o(done[0]),
    .err_o(err[0]), .addr_mem_o(amem[0]), .d_mem_o(dmem[0]), .we_mem_o(we[0]));

  mem_store_serializer #(.ADDR_W(32), .CHECK_ALIGN(1'b0)) dut_na (
    .dclk(dclk), .rst(rst), .rdy(rdy), .req_i(req_i), .addr_i(addr_i),
    .data_i(data_i), .width_i(width_i), .busy_o(busy[1]), .done_o(done[1]),
    .err_o(err[1]), .addr_mem_o(amem[1]), .d_mem_o(dmem[1]), .we_mem_o(we[1]));

  int n_cmp = 0, n_mis = 0, cyc = 0, sel = 0;
  int n_done_seen, n_err_seen, busy_cnt, done_cyc, t0;
  logic [31:0] wl_a[$];
  logic [7:0]  wl_d[$];

  // reference model: a store is "k rdy-ticks after acceptance", outputs derived arithmetically
  logic        m_act [2];
  int          m_k [2], m_n [2];
  logic [31:0] m_base [2], m_data [2];
  logic        e_busy [2], e_done [2], e_err [2], e_we [2];
  logic [31:0] e_addr [2];
  logic [7:0]  e_d [2];

  function automatic int nbytes(logic [1:0] w);
    return (w == 2'd0) ? 1 : (w == 2'd1) ? 2 : (w == 2'd2) ? 4 : 0;
  endfunction

  function automatic bit legal(int j, logic [31:0] a, logic [1:0] w);
    if (w == 2'd3) return 1'b0;
    if (j == 0 && (a % 32'(nbytes(w))) != 0) return 1'b0;
    return 1'b1;
  endfunction

  task automatic model_step(int j);
    if (rst) begin
      m_act[j] = 1'b0; e_busy[j] = 1'b0; e_done[j] = 1'b0; e_err[j] = 1'b0;
      e_we[j] = 1'b0; e_addr[j] = 32'd0; e_d[j] = 8'd0;
    end else if (rdy) begin
      e_done[j] = 1'b0;
      e_err[j]  = 1'b0;
      if (m_act[j]) begin
        m_k[j]++;
        if (m_k[j] < m_n[j]) begin
          e_addr[j] = m_base[j] + 32'(m_k[j]);
          e_d[j]    = 8'(m_data[j] >> (8 * m_k[j]));
        end else begin
          m_act[j] = 1'b0; e_we[j] = 1'b0; e_busy[j] = 1'b0; e_done[j] = 1'b1;
        end
      end else begin
        e_we[j] = 1'b0;
        if (req_i) begin
          if (!legal(j, addr_i, width_i)) e_err[j] = 1'b1;
          else begin
            m_act[j] = 1'b1; m_k[j] = 0; m_n[j] = nbytes(width_i);
            m_base[j] = addr_i; m_data[j] = data_i;
            e_we[j] = 1'b1; e_busy[j] = 1'b1; e_addr[j] = addr_i; e_d[j] = data_i[7:0];
          end
        end
      end
    end
  endtask

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic tick();
    if (rdy && we[sel] === 1'b1) begin
      wl_a.push_back(amem[sel]);
      wl_d.push_back(dmem[sel]);
    end
    @(posedge dclk);
    for (int j = 0; j < 2; j++) model_step(j);
    #1;
    cyc++;
    if (busy[sel]) busy_cnt++;
    if (done[sel]) begin n_done_seen++; done_cyc = cyc; end
    if (err[sel]) n_err_seen++;
    for (int j = 0; j < 2; j++) begin
      chk($sformatf("model busy[%0d]", j), 32'(busy[j]), 32'(e_busy[j]));
      chk($sformatf("model done[%0d]", j), 32'(done[j]), 32'(e_done[j]));
      chk($sformatf("model err[%0d]", j),  32'(err[j]),  32'(e_err[j]));
      chk($sformatf("model we[%0d]", j),   32'(we[j]),   32'(e_we[j]));
      chk($sformatf("model addr[%0d]", j), amem[j],      e_addr[j]);
      chk($sformatf("model data[%0d]", j), 32'(dmem[j]), 32'(e_d[j]));
    end
  endtask

  task automatic clear_obs();
    wl_a.delete(); wl_d.delete();
    n_done_seen = 0; n_err_seen = 0; busy_cnt = 0; done_cyc = -1;
  endtask

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
    logic [1:0]  w;
    int          inst;
    bit          e_err;
    int          n;
  } vec_t;

  vec_t tbl [10];

  initial begin
    tbl[0] = '{32'h0000_0100, 32'hDEAD_BEEF, 2'd2, 0, 1'b0, 4};
    tbl[1] = '{32'h0000_0007, 32'h0000_00A5, 2'd0, 0, 1'b0, 1};
    tbl[2] = '{32'h0000_0006, 32'h0000_1234, 2'd1, 0, 1'b0, 2};
    tbl[3] = '{32'h0000_0102, 32'h0BAD_F00D, 2'd2, 0, 1'b1, 0};
    tbl[4] = '{32'h0000_0040, 32'h1111_1111, 2'd3, 0, 1'b1, 0};
    tbl[5] = '{32'hFFFF_FFFE, 32'hAABB_CCDD, 2'd2, 1, 1'b0, 4};
    tbl[6] = '{32'h0000_0005, 32'h0000_9876, 2'd1, 0, 1'b1, 0};
    tbl[7] = '{32'h0000_0005, 32'h0000_9876, 2'd1, 1, 1'b0, 2};
    tbl[8] = '{32'h0000_0003, 32'h1234_5678, 2'd3, 1, 1'b1, 0};
    tbl[9] = '{32'hFFFF_FFFF, 32'h0000_00C3, 2'd0, 0, 1'b0, 1};

    rst = 1'b1; rdy = 1'b0; req_i = 1'b0; addr_i = 32'h55; data_i = 32'h66; width_i = 2'd2;
    clear_obs();
    tick();
    rdy = 1'b1;
    tick();
    chk("reset busy", 32'(busy[0]), 32'd0);
    chk("reset we",   32'(we[0]),   32'd0);
    chk("reset addr", amem[0],      32'd0);
    chk("reset data", 32'(dmem[0]), 32'd0);
    rst = 1'b0;
    tick();

    // table-driven single requests
    for (int v = 0; v < 10; v++) begin
      sel = tbl[v].inst;
      clear_obs();
      req_i = 1'b1; addr_i = tbl[v].a; data_i = tbl[v].d; width_i = tbl[v].w;
      tick();
      t0 = cyc;
      req_i = 1'b0; addr_i = $urandom; data_i = $urandom; width_i = 2'($urandom);
      repeat (7) tick();
      chk($sformatf("v%0d err pulses", v),  32'(n_err_seen),  32'(tbl[v].e_err));
      chk($sformatf("v%0d done pulses", v), 32'(n_done_seen), 32'(!tbl[v].e_err));
      chk($sformatf("v%0d writes", v),      32'(wl_a.size()), 32'(tbl[v].n));
      chk($sformatf("v%0d busy cycles", v), 32'(busy_cnt),    32'(tbl[v].n));
      if (!tbl[v].e_err) chk($sformatf("v%0d latency", v), 32'(done_cyc - t0), 32'(tbl[v].n));
      for (int i = 0; i < wl_a.size() && i < tbl[v].n; i++) begin
        chk($sformatf("v%0d waddr%0d", v, i), wl_a[i], tbl[v].a + 32'(i));
        chk($sformatf("v%0d wdata%0d", v, i), 32'(wl_d[i]), 32'(8'(tbl[v].d >> (8 * i))));
      end
    end
    sel = 0;

    // stall of 3 cycles after the second byte
    clear_obs();
    req_i = 1'b1; addr_i = 32'h200; data_i = 32'h1122_3344; width_i = 2'd2;
    tick();
    t0 = cyc;
    req_i = 1'b0;
    tick();
    chk("stall pre addr", amem[0], 32'h201);
    chk("stall pre data", 32'(dmem[0]), 32'h33);
    rdy = 1'b0;
    repeat (3) begin
      tick();
      chk("stall addr", amem[0], 32'h201);
      chk("stall data", 32'(dmem[0]), 32'h33);
      chk("stall we",   32'(we[0]),   32'd1);
      chk("stall busy", 32'(busy[0]), 32'd1);
      chk("stall done", 32'(done[0]), 32'd0);
    end
    rdy = 1'b1;
    tick();
    chk("resume addr", amem[0], 32'h202);
    chk("resume data", 32'(dmem[0]), 32'h22);
    tick();
    tick();
    chk("stall done", 32'(done[0]), 32'd1);
    chk("stall latency", 32'(done_cyc - t0), 32'd7);
    tick();

    // reset during a word store
    clear_obs();
    req_i = 1'b1; addr_i = 32'h300; data_i = 32'hA1B2_C3D4; width_i = 2'd2;
    tick();
    req_i = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst we",   32'(we[0]),   32'd0);
    chk("rst busy", 32'(busy[0]), 32'd0);
    chk("rst addr", amem[0],      32'd0);
    chk("rst done", 32'(done[0]), 32'd0);
    tick();
    chk("post rst done", 32'(done[0]), 32'd0);
    req_i = 1'b1; addr_i = 32'h9; data_i = 32'h55; width_i = 2'd0;
    tick();
    req_i = 1'b0;
    chk("fresh we",   32'(we[0]),   32'd1);
    chk("fresh addr", amem[0],      32'h9);
    chk("fresh data", 32'(dmem[0]), 32'h55);
    tick();
    chk("fresh done", 32'(done[0]), 32'd1);
    chk("fresh busy", 32'(busy[0]), 32'd0);
    tick();

    // request held while busy
    req_i = 1'b1; addr_i = 32'h400; data_i = 32'hCAFE_F00D; width_i = 2'd2;
    tick();
    clear_obs();
    addr_i = 32'h500; data_i = 32'h0102_0304;
    repeat (4) tick();
    chk("busyreq done", 32'(done[0]), 32'd1);
    chk("busyreq busy", 32'(busy[0]), 32'd0);
    chk("busyreq writes", 32'(wl_a.size()), 32'd4);
    for (int i = 0; i < wl_a.size() && i < 4; i++) begin
      chk($sformatf("busyreq waddr%0d", i), wl_a[i], 32'h400 + 32'(i));
      chk($sformatf("busyreq wdata%0d", i), 32'(wl_d[i]), 32'(8'(32'hCAFE_F00D >> (8 * i))));
    end
    tick();
    req_i = 1'b0;
    chk("second accept busy", 32'(busy[0]), 32'd1);
    chk("second accept addr", amem[0], 32'h500);
    chk("second accept data", 32'(dmem[0]), 32'h04);
    repeat (5) tick();

    // randomized traffic, checked by the model on both instances
    for (int i = 0; i < 600; i++) begin
      rst     = ($urandom_range(0, 63) == 0);
      rdy     = ($urandom_range(0, 7) != 0);
      req_i   = $urandom_range(0, 1);
      width_i = 2'($urandom);
      addr_i  = ($urandom_range(0, 1) == 0) ? 32'($urandom_range(0, 15)) : $urandom;
      data_i  = $urandom;
      tick();
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
